// File: rtl/plexers_pkg.sv
// Shared definitions for the plexers library: channel indices and the
// holding-register occupancy state used by the demultiplexer channels.
package plexers_pkg;

    localparam logic CH_0 = 1'b0;
    localparam logic CH_1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/demux_channel_reg.sv
// One output channel of the demultiplexer: a one-entry holding register with
// its occupancy flag and a wrapping counter of beats delivered downstream.
module demux_channel_reg #(
    parameter int nrOfBits = 1,
    parameter int cntBits  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [nrOfBits-1:0] load_data,
    input  logic                take,
    output logic                full,
    output logic [nrOfBits-1:0] data,
    output logic [cntBits-1:0]  count
);
    import plexers_pkg::*;

    chan_state_t         state;
    chan_state_t         state_next;
    logic [nrOfBits-1:0] data_reg;
    logic [cntBits-1:0]  count_reg;
    logic                drain;

    assign drain = (state == FULL) && take;

    // A load in the same cycle as a drain keeps the entry full (pass-through).
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = FULL;
        end else if (drain) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                data_reg <= load_data;
            end
            if (drain) begin
                count_reg <= count_reg + cntBits'(1);
            end
        end
    end

    assign full  = (state == FULL);
    assign data  = full ? data_reg : '0;
    assign count = count_reg;

endmodule

// File: rtl/stream_demux_bus_2.sv
// Registered 1-to-2 stream demultiplexer: each input beat is steered by sel
// into one of two independently drained one-entry channel buffers.
module stream_demux_bus_2 #(
    parameter int nrOfBits = 1,
    parameter int cntBits  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [nrOfBits-1:0] demuxIn,
    input  logic                sel,
    input  logic                inValid,
    output logic                inReady,
    output logic [nrOfBits-1:0] demuxOut_0,
    output logic                outValid_0,
    input  logic                outReady_0,
    output logic [nrOfBits-1:0] demuxOut_1,
    output logic                outValid_1,
    input  logic                outReady_1,
    output logic [cntBits-1:0]  count_0,
    output logic [cntBits-1:0]  count_1
);
    import plexers_pkg::*;

    logic sel_full;
    logic sel_take;
    logic accept;
    logic load_0;
    logic load_1;

    // Only the addressed channel gates acceptance; inValid never feeds inReady.
    assign sel_full = (sel == CH_1) ? outValid_1 : outValid_0;
    assign sel_take = (sel == CH_1) ? outReady_1 : outReady_0;
    assign inReady  = enable & (~sel_full | sel_take);
    assign accept   = inValid & inReady;
    assign load_0   = accept & (sel == CH_0);
    assign load_1   = accept & (sel == CH_1);

    demux_channel_reg #(
        .nrOfBits (nrOfBits),
        .cntBits  (cntBits)
    ) u_ch0 (
        .clock     (clock),
        .reset     (reset),
        .load      (load_0),
        .load_data (demuxIn),
        .take      (outReady_0),
        .full      (outValid_0),
        .data      (demuxOut_0),
        .count     (count_0)
    );

    demux_channel_reg #(
        .nrOfBits (nrOfBits),
        .cntBits  (cntBits)
    ) u_ch1 (
        .clock     (clock),
        .reset     (reset),
        .load      (load_1),
        .load_data (demuxIn),
        .take      (outReady_1),
        .full      (outValid_1),
        .data      (demuxOut_1),
        .count     (count_1)
    );

endmodule
